pong_frame_sequencer: RTL and testbench

Schedules the once-per-frame game-logic updates of the Pong design. It watches the CRT controller's `ypos` and detects the start of vertical blanking. It then steps the game unit through four update stages (paddle, ball, collision, score) with a req/ack handshake per stage, so that game state never changes during active video. It sits between the CRT timing controller and the game unit, driven by the 125 MHz system clock.

---
 rtl/pong_pkg.sv | 34 +++
 rtl/pong_stage_timer.sv | 27 ++
 rtl/pong_frame_sequencer.sv | 119 +++++++++++
 tb/tb_pong_frame_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong frame sequencer: FSM state encoding,
// stage bit positions in req/ack, and the default visible-line count.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PADDLE,
        ST_BALL,
        ST_COLLIDE,
        ST_SCORE
    } state_t;

    localparam int STG_PADDLE  = 0;
    localparam int STG_BALL    = 1;
    localparam int STG_COLLIDE = 2;
    localparam int STG_SCORE   = 3;

    localparam logic [9:0] NUM_LINES_DEF = 10'd480;

    // One-hot request pattern presented while the FSM sits in a given state.
    function automatic logic [3:0] stage_req(input state_t s);
        logic [3:0] r;
        r = '0;
        case (s)
            ST_PADDLE:  r[STG_PADDLE]  = 1'b1;
            ST_BALL:    r[STG_BALL]    = 1'b1;
            ST_COLLIDE: r[STG_COLLIDE] = 1'b1;
            ST_SCORE:   r[STG_SCORE]   = 1'b1;
            default:    r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pong_stage_timer.sv
// Per-stage cycle counter; expired is high in the TIMEOUT-th cycle of a stage
// so a stage without ack lasts exactly TIMEOUT cycles.
module pong_stage_timer #(
    parameter logic [9:0] TIMEOUT = 10'd1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [9:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 10'd1;
        end
    end

    assign expired = en && (count == (TIMEOUT - 10'd1));

endmodule

// File: rtl/pong_frame_sequencer.sv
// Runs the once-per-frame game updates (paddle, ball, collide, score) during
// vertical blanking, one req/ack handshake per stage.
module pong_frame_sequencer
    import pong_pkg::*;
#(
    parameter logic [9:0] NUM_LINES = NUM_LINES_DEF,
    parameter logic [9:0] TIMEOUT   = 10'd1023,
    parameter logic [3:0] SPEED_DIV = 4'd1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  ypos,
    input  logic        enable,
    input  logic        pause,
    input  logic [3:0]  ack,
    input  logic        err_clr,
    output logic [3:0]  req,
    output logic        busy,
    output logic [15:0] frame_count,
    output logic        timeout_err,
    output logic        overrun
);

    state_t     state;
    logic       vblank;
    logic       vblank_d;
    logic       trigger;
    logic       abort;
    logic       ack_hit;
    logic       expired;
    logic       stage_done;
    logic       timeout_set;
    logic       run_ball;
    logic [3:0] div_cnt;

    assign vblank  = (ypos >= NUM_LINES);
    assign trigger = (state == ST_IDLE) && vblank && !vblank_d && enable && !pause;
    // Active video starting while a sequence is still running.
    assign abort   = !vblank && vblank_d && (state != ST_IDLE);

    always_comb begin
        ack_hit = 1'b0;
        case (state)
            ST_PADDLE:  ack_hit = ack[STG_PADDLE];
            ST_BALL:    ack_hit = ack[STG_BALL];
            ST_COLLIDE: ack_hit = ack[STG_COLLIDE];
            ST_SCORE:   ack_hit = ack[STG_SCORE];
            default:    ack_hit = 1'b0;
        endcase
    end

    assign stage_done  = (state != ST_IDLE) && (ack_hit || expired);
    assign timeout_set = stage_done && !ack_hit && !abort;

    pong_stage_timer #(.TIMEOUT(TIMEOUT)) u_stage_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (trigger || stage_done || abort),
        .en      (state != ST_IDLE),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            req         <= '0;
            busy        <= 1'b0;
            frame_count <= '0;
            div_cnt     <= '0;
            run_ball    <= 1'b0;
            vblank_d    <= 1'b1;
            timeout_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            vblank_d    <= vblank;
            timeout_err <= timeout_set || (timeout_err && !err_clr);
            overrun     <= abort || (overrun && !err_clr);
            if (abort) begin
                state <= ST_IDLE;
                req   <= '0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: if (trigger) begin
                        state       <= ST_PADDLE;
                        req         <= stage_req(ST_PADDLE);
                        busy        <= 1'b1;
                        frame_count <= frame_count + 16'd1;
                        run_ball    <= (div_cnt == 4'd0);
                        div_cnt     <= (div_cnt >= SPEED_DIV - 4'd1) ? 4'd0 : div_cnt + 4'd1;
                    end
                    ST_PADDLE: if (stage_done) begin
                        state <= run_ball ? ST_BALL : ST_SCORE;
                        req   <= stage_req(run_ball ? ST_BALL : ST_SCORE);
                    end
                    ST_BALL: if (stage_done) begin
                        state <= ST_COLLIDE;
                        req   <= stage_req(ST_COLLIDE);
                    end
                    ST_COLLIDE: if (stage_done) begin
                        state <= ST_SCORE;
                        req   <= stage_req(ST_SCORE);
                    end
                    ST_SCORE: if (stage_done) begin
                        state <= ST_IDLE;
                        req   <= '0;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                        req   <= '0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pong_frame_sequencer.sv
// Directed bench: instance a uses SPEED_DIV=1/TIMEOUT=16, instance b uses
// SPEED_DIV=3/TIMEOUT=1023; expected values are hand-derived constants.
module tb_pong_frame_sequencer;

    logic        clk;
    logic        rst_n;

    logic [9:0]  ypos_a, ypos_b;
    logic        enable_a, enable_b, pause_a, pause_b, err_clr_a, err_clr_b;
    logic [3:0]  ack_a, ack_b, req_a, req_b;
    logic        busy_a, busy_b, timeout_err_a, timeout_err_b, overrun_a, overrun_b;
    logic [15:0] frame_count_a, frame_count_b;

    int n_checks = 0;
    int n_fail   = 0;
    int busy_cyc = 0;
    int cnt      = 0;

    pong_frame_sequencer #(.TIMEOUT(10'd16), .SPEED_DIV(4'd1)) dut_a (
        .clk(clk), .rst_n(rst_n), .ypos(ypos_a), .enable(enable_a), .pause(pause_a),
        .ack(ack_a), .err_clr(err_clr_a), .req(req_a), .busy(busy_a),
        .frame_count(frame_count_a), .timeout_err(timeout_err_a), .overrun(overrun_a)
    );

    pong_frame_sequencer #(.TIMEOUT(10'd1023), .SPEED_DIV(4'd3)) dut_b (
        .clk(clk), .rst_n(rst_n), .ypos(ypos_b), .enable(enable_b), .pause(pause_b),
        .ack(ack_b), .err_clr(err_clr_b), .req(req_b), .busy(busy_b),
        .frame_count(frame_count_b), .timeout_err(timeout_err_b), .overrun(overrun_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic trigger_a();
        ypos_a = 10'd0;
        step();
        ypos_a = 10'd480;
        step();
    endtask

    task automatic trigger_b();
        ypos_b = 10'd0;
        step();
        ypos_b = 10'd480;
        step();
    endtask

    // Check the active request, then ack it after lat extra cycles.
    task automatic stage_a(input logic [3:0] exp, input int lat);
        check("stage_req_a", req_a, exp);
        for (int i = 0; i <= lat; i++) begin
            if (busy_a) busy_cyc++;
            if (i == lat) ack_a = exp;
            step();
        end
        ack_a = '0;
    endtask

    task automatic stage_b(input logic [3:0] exp);
        check("stage_req_b", req_b, exp);
        ack_b = exp;
        step();
        ack_b = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        ypos_a = '0; ypos_b = '0;
        enable_a = 1'b1; enable_b = 1'b1;
        pause_a = 1'b0; pause_b = 1'b0;
        ack_a = '0; ack_b = '0;
        err_clr_a = 1'b0; err_clr_b = 1'b0;
        #12;
        check("rst_req_a", req_a, 4'b0000);
        check("rst_busy_a", busy_a, 1'b0);
        check("rst_fc_a", frame_count_a, 16'd0);
        check("rst_terr_a", timeout_err_a, 1'b0);
        check("rst_ovr_a", overrun_a, 1'b0);
        check("rst_req_b", req_b, 4'b0000);
        check("rst_busy_b", busy_b, 1'b0);
        rst_n = 1'b1;
        step();

        // Acks 3 cycles after each req: four 4-cycle stages.
        ypos_a = 10'd479;
        step();
        ypos_a = 10'd480;
        step();
        busy_cyc = 0;
        check("t1_busy_start", busy_a, 1'b1);
        stage_a(4'b0001, 3);
        stage_a(4'b0010, 3);
        stage_a(4'b0100, 3);
        stage_a(4'b1000, 3);
        check("t1_req_end", req_a, 4'b0000);
        check("t1_busy_end", busy_a, 1'b0);
        check("t1_busy_cycles", busy_cyc, 16);
        check("t1_fc", frame_count_a, 16'd1);

        // BALL stage timeout.
        trigger_a();
        stage_a(4'b0001, 0);
        cnt = 0;
        while (req_a[1] && cnt < 40) begin
            cnt++;
            step();
        end
        check("to_ball_len", cnt, 16);
        check("to_next_req", req_a, 4'b0100);
        check("to_flag", timeout_err_a, 1'b1);
        stage_a(4'b0100, 0);
        stage_a(4'b1000, 0);
        check("to_req_end", req_a, 4'b0000);
        check("to_flag_sticky", timeout_err_a, 1'b1);
        check("to_fc", frame_count_a, 16'd2);
        err_clr_a = 1'b1;
        step();
        err_clr_a = 1'b0;
        check("clr_lone", timeout_err_a, 1'b0);

        // ack[2] ignored in PADDLE; err_clr loses against a same-cycle timeout.
        trigger_a();
        check("ig_req_start", req_a, 4'b0001);
        ack_a = 4'b0100;
        repeat (15) step();
        check("ig_ack2", req_a, 4'b0001);
        check("ig_terr_pre", timeout_err_a, 1'b0);
        ack_a = '0;
        err_clr_a = 1'b1;
        step();
        err_clr_a = 1'b0;
        check("clr_vs_set_req", req_a, 4'b0010);
        check("clr_vs_set_flag", timeout_err_a, 1'b1);
        stage_a(4'b0010, 0);
        stage_a(4'b0100, 0);
        stage_a(4'b1000, 0);
        check("ig_fc", frame_count_a, 16'd3);

        // Divided ball speed on instance b.
        trigger_b();
        stage_b(4'b0001);
        stage_b(4'b0010);
        stage_b(4'b0100);
        stage_b(4'b1000);
        check("div_f1_end", req_b, 4'b0000);
        trigger_b();
        stage_b(4'b0001);
        stage_b(4'b1000);
        check("div_f2_end", req_b, 4'b0000);
        trigger_b();
        stage_b(4'b0001);
        stage_b(4'b1000);
        check("div_f3_busy", busy_b, 1'b0);
        check("div_fc", frame_count_b, 16'd3);

        pause_b = 1'b1;
        trigger_b();
        check("pause_busy", busy_b, 1'b0);
        check("pause_fc", frame_count_b, 16'd3);
        pause_b = 1'b0;

        // Overrun: vblank ends with PADDLE unacknowledged.
        trigger_b();
        check("ov_req_start", req_b, 4'b0001);
        repeat (5) step();
        check("ov_req_wait", req_b, 4'b0001);
        ypos_b = 10'd524;
        step();
        ypos_b = 10'd0;
        step();
        check("ov_req", req_b, 4'b0000);
        check("ov_busy", busy_b, 1'b0);
        check("ov_flag", overrun_b, 1'b1);
        check("ov_fc", frame_count_b, 16'd4);
        check("ov_terr", timeout_err_b, 1'b0);
        ypos_b = 10'd480;
        step();
        check("ov_retrig_req", req_b, 4'b0001);
        check("ov_retrig_fc", frame_count_b, 16'd5);
        pause_b = 1'b1;
        enable_b = 1'b0;
        stage_b(4'b0001);
        stage_b(4'b1000);
        pause_b = 1'b0;
        enable_b = 1'b1;
        check("midseq_busy", busy_b, 1'b0);
        check("ov_sticky", overrun_b, 1'b1);

        // Asynchronous reset in the middle of BALL.
        trigger_a();
        stage_a(4'b0001, 0);
        check("mr_in_ball", req_a, 4'b0010);
        #3 rst_n = 1'b0;
        #1;
        check("mr_req", req_a, 4'b0000);
        check("mr_busy", busy_a, 1'b0);
        check("mr_fc", frame_count_a, 16'd0);
        check("mr_terr", timeout_err_a, 1'b0);
        check("mr_ovr", overrun_a, 1'b0);
        check("mr_fc_b", frame_count_b, 16'd0);
        check("mr_ovr_b", overrun_b, 1'b0);
        #2 rst_n = 1'b1;
        repeat (3) step();
        check("mr_no_trig", busy_a, 1'b0);
        trigger_a();
        check("mr_trig_req", req_a, 4'b0001);
        check("mr_trig_fc", frame_count_a, 16'd1);
        stage_a(4'b0001, 0);
        stage_a(4'b0010, 0);
        stage_a(4'b0100, 0);
        stage_a(4'b1000, 0);
        check("mr_end_busy", busy_a, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
